comma_aligner_10b: RTL

- Word aligner that sits directly upstream of the 8b10b decoder.
- Takes unaligned 10-bit parallel words from the deserializer and searches a 20-bit window for the K28.5/K28.1/K28.7 comma (abcdeif = 0011111 or 1100000) at all 10 bit offsets.
- Emits symbol-aligned 10-bit words that feed the decoder's din/en directly.
- Runs a lock state machine (LOSS/ACQ/LOCKED) driven by comma repetition and by error feedback from the decoder.

---
 rtl/v8b10b_pkg.sv | 23 ++
 rtl/comma_detect_10b.sv | 14 +
 rtl/comma_aligner_10b.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/v8b10b_pkg.sv
// rtl/v8b10b_pkg.sv - shared 8b10b symbol constants, lock states and helpers
package v8b10b_pkg;

  localparam int SYM_W = 10;

  localparam logic [6:0] COMMA_P = 7'b0011111;
  localparam logic [6:0] COMMA_N = 7'b1100000;

  typedef enum logic [1:0] {
    LOSS   = 2'd0,
    ACQ    = 2'd1,
    LOCKED = 2'd2
  } lock_state_t;

  function automatic logic is_comma(input logic [6:0] bits);
    return (bits == COMMA_P) || (bits == COMMA_N);
  endfunction

  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

endpackage

// File: rtl/comma_detect_10b.sv
// rtl/comma_detect_10b.sv - comma search over a 20-bit window at all ten offsets
module comma_detect_10b
  import v8b10b_pkg::*;
(
  input  logic [2*SYM_W-1:0] win,
  output logic [SYM_W-1:0]   hit
);

  // Offset k looks at abcdeif of the symbol starting k bits after the oldest bit.
  for (genvar k = 0; k < SYM_W; k++) begin : g_off
    assign hit[k] = is_comma(win[2*SYM_W-1-k -: 7]);
  end

endmodule

// File: rtl/comma_aligner_10b.sv
// rtl/comma_aligner_10b.sv - 10b word aligner with LOSS/ACQ/LOCKED comma lock FSM
module comma_aligner_10b
  import v8b10b_pkg::*;
#(
  parameter int LOCK_COMMAS = 3,
  parameter int ERR_MAX     = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [9:0] din,
  input  logic       err_in,
  input  logic       err_vld,
  output logic [9:0] dout,
  output logic       vout,
  output logic       comma,
  output logic       aligned,
  output logic [3:0] offset
);

  localparam logic [3:0] LOCK_N = 4'(LOCK_COMMAS);
  localparam logic [3:0] ERR_N  = 4'(ERR_MAX);

  logic [9:0]  w0, w1;
  logic        primed, en_d;
  logic [19:0] win;
  logic [9:0]  hit;
  logic [9:0]  cand;
  logic [3:0]  low_hit, sel_off;
  logic        eval, err_q, any_hit, cur_hit;

  lock_state_t state, state_nx;
  logic [3:0]  good_cnt, good_nx, err_cnt, err_nx, off_nx;

  assign win     = {w0, w1};
  assign eval    = en_d;
  assign err_q   = err_vld & err_in;
  assign any_hit = |hit;
  assign cur_hit = hit[offset];

  comma_detect_10b u_detect (
    .win (win),
    .hit (hit)
  );

  always_comb begin
    low_hit = '0;
    for (int k = SYM_W - 1; k >= 0; k--) begin
      if (hit[k]) low_hit = 4'(k);
    end
  end

  always_comb begin
    sel_off = offset;
    if (!cur_hit && any_hit && state != LOCKED) sel_off = low_hit;
  end

  assign cand = 10'(win >> (5'd10 - {1'b0, sel_off}));

  always_comb begin
    state_nx = state;
    good_nx  = good_cnt;
    err_nx   = err_cnt;
    off_nx   = offset;
    case (state)
      LOSS: begin
        if (eval && any_hit) begin
          off_nx   = sel_off;
          good_nx  = 4'd1;
          err_nx   = '0;
          state_nx = (LOCK_COMMAS == 1) ? LOCKED : ACQ;
        end
      end
      ACQ: begin
        if (err_q) begin
          state_nx = LOSS;
          good_nx  = '0;
        end else if (eval && cur_hit) begin
          good_nx = sat_inc(good_cnt);
          if (good_nx >= LOCK_N) begin
            state_nx = LOCKED;
            err_nx   = '0;
          end
        end else if (eval && any_hit) begin
          off_nx  = sel_off;
          good_nx = 4'd1;
        end
      end
      LOCKED: begin
        // A foreign-offset comma is suspicious, not a reason to move.
        if (eval && cur_hit) err_nx = err_q ? 4'd1 : 4'd0;
        else if (err_q || (eval && any_hit)) err_nx = sat_inc(err_cnt);
        if (err_nx >= ERR_N) begin
          state_nx = LOSS;
          good_nx  = '0;
          err_nx   = '0;
        end
      end
      default: state_nx = LOSS;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w0       <= '0;
      w1       <= '0;
      primed   <= 1'b0;
      en_d     <= 1'b0;
      state    <= LOSS;
      good_cnt <= '0;
      err_cnt  <= '0;
      offset   <= '0;
      aligned  <= 1'b0;
      dout     <= '0;
      comma    <= 1'b0;
      vout     <= 1'b0;
    end else begin
      if (en) begin
        w0     <= w1;
        w1     <= din;
        primed <= 1'b1;
      end
      // Only words arriving behind an already-filled w1 make a full window.
      en_d     <= en & primed;
      state    <= state_nx;
      good_cnt <= good_nx;
      err_cnt  <= err_nx;
      offset   <= off_nx;
      aligned  <= (state_nx == LOCKED);
      if (eval) begin
        dout  <= cand;
        comma <= hit[sel_off];
        vout  <= 1'b1;
      end else begin
        vout  <= 1'b0;
      end
    end
  end

endmodule
